frame_renderer: RTL and testbench
=================================

FRAME_RENDERER -- requirements
Module: frame_renderer

Parameters
REQ-001 SCR_W, 160, screen width in pixels and grid columns.
REQ-002 SCR_H, 120, screen height in pixels and grid rows.
REQ-003 SHIP_W, 8, ship sprite width and height in pixels.
REQ-004 C_BG / C_USER / C_ENEMY / C_SHOT, 3'b000 / 3'b010 / 3'b100 / 3'b111, colour codes for background, user ship, enemy ship and grid shot.

Interface
REQ-005 clk  in  1  single system clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  frame request, one cycle wide, sampled in IDLE only.
REQ-008 user_x  in  8  user ship left column.
REQ-009 enemy_x  in  8  enemy ship left column.
REQ-010 grid  in  SCR_W*SCR_H  shot bitmap; bit index = row*SCR_W + col; 1 = shot present.
REQ-011 x  out  8  pixel column to the VGA adapter.
REQ-012 y  out  7  pixel row to the VGA adapter.
REQ-013 colour  out  3  pixel colour to the VGA adapter.
REQ-014 plot  out  1  write enable to the VGA adapter; x, y and colour are valid when it is 1.
REQ-015 busy  out  1  high from frame acceptance until the last pixel is emitted.
REQ-016 done  out  1  one-cycle pulse at frame completion.

Function
REQ-017 The FSM SHALL have three states: IDLE, DRAW and FINISH.
- IDLE->DRAW on start=1.
- DRAW->FINISH after pixel (SCR_W-1, SCR_H-1) is registered.
- FINISH->IDLE unconditionally after one cycle.
REQ-018 On accepting start, the block SHALL latch user_x and enemy_x into snapshot registers and load the column and row counters with 0,0; every pixel in the frame uses these snapshots.
REQ-019 In DRAW, the block SHALL emit one pixel per cycle in raster order: the column increments first; at SCR_W-1 the column wraps to 0 and the row increments.
REQ-020 x, y, colour and plot SHALL be registered; the pixel at counter (c,r) appears on the outputs one cycle after the counters hold (c,r).
REQ-021 plot SHALL be 1 for exactly SCR_W*SCR_H = 19200 consecutive cycles per frame, starting the cycle after start is accepted.
REQ-022 The user ship region SHALL be rows SCR_H-SHIP_W..SCR_H-1 and columns user_x..user_x+SHIP_W-1.
REQ-023 The enemy ship region SHALL be rows 0..SHIP_W-1 and columns enemy_x..enemy_x+SHIP_W-1.
REQ-024 Column range comparisons SHALL use 9-bit arithmetic; columns at or beyond SCR_W are clipped (not drawn), with no wrap to column 0.
REQ-025 Colour priority SHALL be: grid bit set -> C_SHOT; else user region -> C_USER; else enemy region -> C_ENEMY; else C_BG.
REQ-026 grid SHALL be read live, at the cycle the counters address the pixel; the producer holds grid stable while busy=1.
REQ-027 busy SHALL rise the cycle after start is accepted and fall in the same cycle that done pulses.
REQ-028 done SHALL be high for exactly one cycle, in FINISH, the cycle after the last plot=1 cycle.
REQ-029 start while busy=1 or in FINISH SHALL be ignored; it is not queued.
REQ-030 start in the same cycle that FINISH->IDLE occurs SHALL be ignored; the next start is honoured only in IDLE.

Reset
REQ-031 reset=0 SHALL immediately force: state IDLE; x=0, y=0, colour=C_BG, plot=0, busy=0, done=0; counters and snapshots to 0.
REQ-032 reset asserted mid-frame SHALL abort the frame with no done pulse; after release the block waits in IDLE for a new start.

Verification
REQ-033 Blank frame: grid=0, user_x=0, enemy_x=100, start pulse -> 19200 plot cycles in raster order, done one cycle after the last; (0,112) is C_USER, (100,0) is C_ENEMY, (50,50) is C_BG.
REQ-034 Priority: grid bit 115*160+3 set, user_x=0 -> (3,115) is C_SHOT and (4,115) is C_USER.
REQ-035 Clipping: user_x=155 -> columns 155..159 of rows 112..119 are C_USER; nothing is drawn at columns 0..2 of those rows.
REQ-036 Snapshot: user_x changed from 10 to 80 mid-frame -> the entire frame draws the ship at column 10.
REQ-037 Ignored start: start re-pulsed at pixel 500 -> the frame still has exactly 19200 plot cycles and a single done pulse.
REQ-038 Reset abort: reset=0 at pixel 1000 -> plot=0 and busy=0 immediately, no done pulse; a fresh start after release gives a full frame.

Source files
------------

// File: rtl/frame_renderer.sv
// Purpose : raster-scan renderer that paints one SCR_W x SCR_H frame (shots, user ship, enemy ship) to a VGA adapter.
// Latency : first pixel appears two cycles after the start cycle, then one pixel per cycle; done one cycle after the last pixel.
// Backpres: none; the adapter must accept one pixel per cycle. A start arriving outside IDLE is dropped, not queued.
//
// Ports:
//   clk, reset(active-low, async)      clock and reset
//   start                              one-cycle frame request, honoured in IDLE only
//   user_x, enemy_x                    ship left columns, snapshotted at frame start
//   grid                               live shot bitmap, bit row*SCR_W+col
//   x, y, colour, plot                 registered pixel write to the adapter
//   busy, done                         frame-in-progress flag and completion pulse
module frame_renderer #(
    parameter int SCR_W   = 160,
    parameter int SCR_H   = 120,
    parameter int SHIP_W  = 8,
    parameter logic [2:0] C_BG    = 3'b000,
    parameter logic [2:0] C_USER  = 3'b010,
    parameter logic [2:0] C_ENEMY = 3'b100,
    parameter logic [2:0] C_SHOT  = 3'b111
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [7:0]             user_x,
    input  logic [7:0]             enemy_x,
    input  logic [SCR_W*SCR_H-1:0] grid,
    output logic [7:0]             x,
    output logic [6:0]             y,
    output logic [2:0]             colour,
    output logic                   plot,
    output logic                   busy,
    output logic                   done
);

    localparam int NPIX = SCR_W * SCR_H;
    localparam int IW   = $clog2(NPIX);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRAW   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  col_q, col_d;
    logic [6:0]  row_q, row_d;
    logic [7:0]  ux_q, ux_d;
    logic [7:0]  ex_q, ex_d;
    logic [7:0]  x_q, x_d;
    logic [6:0]  y_q, y_d;
    logic [2:0]  colour_q, colour_d;
    logic        plot_q, plot_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [IW-1:0] pix_idx;
    logic [8:0]    col9;
    logic [8:0]    ux_end;
    logic [8:0]    ex_end;
    logic          in_user;
    logic          in_enemy;
    logic          shot;
    logic [2:0]    pix_colour;
    logic          col_last;
    logic          row_last;
    logic          last_out;

    // Pixel classification for the pixel the counters address this cycle.
    // Ship extents are computed in 9 bits so a ship near the right edge
    // clips instead of wrapping back onto column 0.
    always_comb begin
        pix_idx  = IW'(row_q) * IW'(SCR_W) + IW'(col_q);
        shot     = grid[pix_idx];
        col9     = {1'b0, col_q};
        ux_end   = {1'b0, ux_q} + 9'(SHIP_W);
        ex_end   = {1'b0, ex_q} + 9'(SHIP_W);
        in_user  = (row_q >= 7'(SCR_H - SHIP_W)) &&
                   (col9 >= {1'b0, ux_q}) && (col9 < ux_end);
        in_enemy = (row_q < 7'(SHIP_W)) &&
                   (col9 >= {1'b0, ex_q}) && (col9 < ex_end);
        if (shot) begin
            pix_colour = C_SHOT;
        end else if (in_user) begin
            pix_colour = C_USER;
        end else if (in_enemy) begin
            pix_colour = C_ENEMY;
        end else begin
            pix_colour = C_BG;
        end
    end

    assign col_last = (col_q == 8'(SCR_W - 1));
    assign row_last = (row_q == 7'(SCR_H - 1));
    // The frame ends once the final pixel is sitting in the output register,
    // so DRAW lasts one cycle beyond the last counter value.
    assign last_out = plot_q && (x_q == 8'(SCR_W - 1)) && (y_q == 7'(SCR_H - 1));

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        ux_d     = ux_q;
        ex_d     = ex_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_DRAW;
                    col_d   = 8'd0;
                    row_d   = 7'd0;
                    ux_d    = user_x;
                    ex_d    = enemy_x;
                    busy_d  = 1'b1;
                end
            end
            S_DRAW: begin
                if (last_out) begin
                    state_d = S_FINISH;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    x_d      = col_q;
                    y_d      = row_q;
                    colour_d = pix_colour;
                    plot_d   = 1'b1;
                    if (col_last) begin
                        col_d = 8'd0;
                        row_d = row_last ? 7'd0 : row_q + 7'd1;
                    end else begin
                        col_d = col_q + 8'd1;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            col_q    <= 8'd0;
            row_q    <= 7'd0;
            ux_q     <= 8'd0;
            ex_q     <= 8'd0;
            x_q      <= 8'd0;
            y_q      <= 7'd0;
            colour_q <= C_BG;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            ux_q     <= ux_d;
            ex_q     <= ex_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_frame_renderer.sv
// Purpose : self-checking bench for frame_renderer: table of pixel probes, whole-frame reference model, corner sequences.
// Latency : checks first plot two cycles after start, done one cycle after the last plot.
// Backpres: not applicable; the bench samples every cycle on the falling edge.
module tb_frame_renderer;

    localparam int W = 160;
    localparam int H = 120;
    localparam int NPIX = W * H;

    logic             clk;
    logic             reset;
    logic             start;
    logic [7:0]       user_x;
    logic [7:0]       enemy_x;
    logic [NPIX-1:0]  grid_r;
    logic [7:0]       x;
    logic [6:0]       y;
    logic [2:0]       colour;
    logic             plot;
    logic             busy;
    logic             done;

    frame_renderer dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .user_x  (user_x),
        .enemy_x (enemy_x),
        .grid    (grid_r),
        .x       (x),
        .y       (y),
        .colour  (colour),
        .plot    (plot),
        .busy    (busy),
        .done    (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference colour from the screen rules: shot beats user ship beats
    // enemy ship beats background; ship extents are plain integer ranges.
    int m_ux;
    int m_ex;
    function automatic logic [2:0] model_colour(input int px, input int py);
        if (grid_r[py * W + px]) return 3'b111;
        if (py >= H - 8 && px >= m_ux && px < m_ux + 8) return 3'b010;
        if (py < 8 && px >= m_ex && px < m_ex + 8) return 3'b100;
        return 3'b000;
    endfunction

    // Monitor: every plotted pixel must be the next raster position with the
    // model colour; the frame buffer keeps what was drawn for probing.
    logic [2:0] fb [0:NPIX-1];
    int exp_idx;
    int bad_pix;
    int first_bad;
    int done_cnt;
    int done_cyc;
    int done_busy;
    int first_plot_cyc;
    int last_plot_cyc;
    int busy_gap;

    always @(negedge clk) begin
        if (plot) begin
            if (exp_idx < NPIX) begin
                if (x !== 8'(exp_idx % W) || y !== 7'(exp_idx / W) ||
                    colour !== model_colour(exp_idx % W, exp_idx / W)) begin
                    if (bad_pix == 0) first_bad = exp_idx;
                    bad_pix++;
                end
                fb[exp_idx] = colour;
            end else begin
                if (bad_pix == 0) first_bad = exp_idx;
                bad_pix++;
            end
            if (exp_idx == 0) first_plot_cyc = cyc;
            if (!busy) busy_gap++;
            last_plot_cyc = cyc;
            exp_idx++;
        end
        if (done) begin
            done_cnt++;
            done_cyc  = cyc;
            done_busy = busy;
        end
    end

    task automatic clear_mon();
        exp_idx   = 0;
        bad_pix   = 0;
        first_bad = -1;
        done_cnt  = 0;
        done_cyc  = -1;
        done_busy = -1;
        first_plot_cyc = -1;
        last_plot_cyc  = -1;
        busy_gap  = 0;
        for (int i = 0; i < NPIX; i++) fb[i] = 3'bxxx;
    endtask

    task automatic start_frame(input int ux, input int ex, output int acc_cyc);
        clear_mon();
        m_ux = ux;
        m_ex = ex;
        user_x  = 8'(ux);
        enemy_x = 8'(ex);
        @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        @(negedge clk);
        acc_cyc = cyc;
        check("busy_rise", {busy, plot}, 2'b10);
    endtask

    task automatic run_frame(input int ux, input int ex, input int restart_at,
                             input int change_at, input int new_ux, input bit fin_start);
        int acc_cyc;
        int timeout;
        bit restarted;
        start_frame(ux, ex, acc_cyc);
        timeout = 0;
        restarted = 0;
        while (!done && timeout < NPIX + 100) begin
            @(posedge clk);
            #2;
            timeout++;
            start = 1'b0;
            if (exp_idx == restart_at && !restarted) begin
                start = 1'b1;
                restarted = 1;
            end
            if (exp_idx == change_at) user_x = 8'(new_ux);
        end
        check("done_seen_in_time", done, 1'b1);
        // Now in the FINISH cycle: an optional start here must be dropped.
        start = fin_start;
        @(posedge clk);
        #2 start = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_after_frame", {busy, plot, done}, 3'b000);
        check("plot_count", exp_idx, NPIX);
        check("first_plot_cycle", first_plot_cyc, acc_cyc + 1);
        check("plot_consecutive", last_plot_cyc - first_plot_cyc, NPIX - 1);
        check("done_count", done_cnt, 1);
        check("done_after_last_plot", done_cyc, last_plot_cyc + 1);
        check("busy_low_at_done", done_busy, 0);
        check("busy_during_plot", busy_gap, 0);
        check($sformatf("frame_pixels_first_bad_%0d", first_bad), bad_pix, 0);
    endtask

    typedef struct {
        int         fr;
        int         px;
        int         py;
        logic [2:0] col;
    } probe_t;

    probe_t probes [$];

    task automatic run_probes(input int fr);
        foreach (probes[i]) begin
            if (probes[i].fr == fr) begin
                check($sformatf("probe_f%0d_%0d_%0d", fr, probes[i].px, probes[i].py),
                      fb[probes[i].py * W + probes[i].px], probes[i].col);
            end
        end
    endtask

    initial begin
        int timeout;
        int rux;
        int rex;

        probes.push_back('{0,   0, 112, 3'b010});
        probes.push_back('{0, 100,   0, 3'b100});
        probes.push_back('{0,  50,  50, 3'b000});
        probes.push_back('{0,   3, 115, 3'b111});
        probes.push_back('{0,   4, 115, 3'b010});
        probes.push_back('{0,   7, 119, 3'b010});
        probes.push_back('{0,   8, 119, 3'b000});
        probes.push_back('{0,   0, 111, 3'b000});
        probes.push_back('{0, 107,   7, 3'b100});
        probes.push_back('{0, 108,   0, 3'b000});
        probes.push_back('{0, 100,   8, 3'b000});
        probes.push_back('{1, 155, 112, 3'b010});
        probes.push_back('{1, 159, 119, 3'b010});
        probes.push_back('{1, 154, 115, 3'b000});
        probes.push_back('{1,   0, 112, 3'b000});
        probes.push_back('{1,   2, 119, 3'b000});
        probes.push_back('{1,  10, 115, 3'b000});
        probes.push_back('{1,  12, 119, 3'b000});
        probes.push_back('{1,   0,   0, 3'b100});

        reset   = 1'b0;
        start   = 1'b0;
        user_x  = 8'd0;
        enemy_x = 8'd0;
        grid_r  = '0;
        clear_mon();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {x, y, colour, plot, busy, done}, 21'd0);
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_start", {busy, plot, done}, 3'b000);

        // Frame 0: blank-ish frame with one shot over the user ship, a start
        // re-pulse mid-frame and another during FINISH.
        grid_r[115 * W + 3] = 1'b1;
        run_frame(0, 100, 500, -1, 0, 1'b1);
        run_probes(0);

        // Abort at pixel 1000 with reset; no done may appear.
        grid_r = '0;
        begin
            int acc_cyc;
            start_frame(155, 0, acc_cyc);
        end
        timeout = 0;
        while (exp_idx < 1000 && timeout < 2000) begin
            @(posedge clk);
            #2 timeout++;
        end
        check("abort_reached_1000", exp_idx, 1000);
        reset = 1'b0;
        #1;
        check("abort_immediate", {plot, busy, done}, 3'b000);
        repeat (3) @(negedge clk);
        check("abort_no_done", done_cnt, 0);
        @(posedge clk);
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_stays_idle", {busy, plot}, 2'b00);

        // Frame 1: clipped ship at 155; user_x moves to 10 mid-frame and must
        // not affect the drawing.
        run_frame(155, 0, -1, 5000, 10, 1'b0);
        run_probes(1);

        // Frame 2: random shots and ship positions, including off-screen.
        for (int i = 0; i < NPIX; i++) grid_r[i] = ($urandom_range(0, 15) == 0);
        rux = $urandom_range(0, 255);
        rex = $urandom_range(0, 255);
        run_frame(rux, rex, $urandom_range(1, NPIX - 2), -1, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
